multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives `aluop` into the existing ALU-control decoder (`littlecontrol`), plus all mux selects and write enables.
- Stalls on a memory-ready handshake and flags unsupported opcodes.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/mc_output_decode.sv | 86 ++++++++
 rtl/multicycle_control.sv | 116 +++++++++++
 tb/tb_multicycle_control.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes and control encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational state to control-vector decode for the multicycle controller
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        // IR and PC only advance once the fetched word is actually there
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
        if (!op_supported(op)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_REG;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsource   = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM sequencing the multicycle MIPS datapath
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          waiting;
  logic          timeout_hit;
  ctrl_t         ctrl, ctrl_g;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Every wait state leaves on mem_ready, so "not waiting" already covers any state change.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready;

  always_comb begin
    stall_d = '0;
    if (waiting) begin
      stall_d = (stall_q == CW'(STALL_LIMIT)) ? stall_q : stall_q + 1'b1;
    end
  end

  assign timeout_hit = waiting && (stall_q == CW'(STALL_LIMIT - 1));

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .op        (op),
    .ctrl      (ctrl)
  );

  // Reset silences everything, so an abandoned store cannot leak a write strobe.
  assign ctrl_g      = reset ? '0 : ctrl;
  assign pcwrite     = ctrl_g.pcwrite;
  assign branch      = ctrl_g.branch;
  assign iord        = ctrl_g.iord;
  assign memread     = ctrl_g.memread;
  assign memwrite    = ctrl_g.memwrite;
  assign irwrite     = ctrl_g.irwrite;
  assign memtoreg    = ctrl_g.memtoreg;
  assign regdst      = ctrl_g.regdst;
  assign regwrite    = ctrl_g.regwrite;
  assign alusrca     = ctrl_g.alusrca;
  assign alusrcb     = ctrl_g.alusrcb;
  assign aluop       = ctrl_g.aluop;
  assign pcsource    = ctrl_g.pcsource;
  assign instr_done  = ctrl_g.instr_done;
  assign illegal_op  = ctrl_g.illegal_op;
  assign mem_timeout = reset ? 1'b0 : timeout_hit;
  assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction-level bench for multicycle_control
module tb_multicycle_control;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [5:0] op;
  logic       pcwrite, branch, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic       instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    int         widx;
  } step_t;

  always #5 clk = ~clk;

  multicycle_control #(.STALL_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .branch      (branch),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      reset     = 1'b1;
      mem_ready = 1'($urandom);
      op        = 6'($urandom);
      @(negedge clk);
      chk("reset_outputs",
          {7'd0, pcwrite, branch, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, mem_timeout, state},
          32'd0);
    end
  endtask

  // Builds the expected cycle-by-cycle walk of one instruction; nsteps < 0 runs it to completion.
  task automatic run_instr(input logic [5:0] iop, input int fw, input int mw, input int nsteps);
    step_t      q[$];
    bit         ill;
    logic [3:0] s, mst;
    bit         last;
    ill = !legal(iop);
    for (int i = 1; i <= fw; i++) q.push_back('{4'd0, 1'b0, i});
    q.push_back('{4'd0, 1'b1, 0});
    q.push_back('{4'd1, 1'($urandom), 0});
    if (iop == 6'b100011 || iop == 6'b101011) begin
      mst = (iop == 6'b100011) ? 4'd3 : 4'd5;
      q.push_back('{4'd2, 1'($urandom), 0});
      for (int i = 1; i <= mw; i++) q.push_back('{mst, 1'b0, i});
      q.push_back('{mst, 1'b1, 0});
      if (iop == 6'b100011) q.push_back('{4'd4, 1'($urandom), 0});
    end else if (iop == 6'b000000) begin
      q.push_back('{4'd6, 1'($urandom), 0});
      q.push_back('{4'd7, 1'($urandom), 0});
    end else if (iop == 6'b000100) begin
      q.push_back('{4'd8, 1'($urandom), 0});
    end else if (iop == 6'b001000) begin
      q.push_back('{4'd9, 1'($urandom), 0});
      q.push_back('{4'd10, 1'($urandom), 0});
    end else if (iop == 6'b000010) begin
      q.push_back('{4'd11, 1'($urandom), 0});
    end

    for (int k = 0; k < q.size() && (nsteps < 0 || k < nsteps); k++) begin
      @(posedge clk); #1;
      reset     = 1'b0;
      mem_ready = q[k].mr;
      op        = (q[k].st == 4'd0) ? 6'($urandom) : iop;
      @(negedge clk);
      s    = q[k].st;
      last = (k == q.size() - 1);
      chk("state", state, s);
      chk("instr_done", instr_done, last);
      chk("irwrite", irwrite, s == 0 && q[k].mr);
      chk("pcwrite", pcwrite, (s == 0 && q[k].mr) || s == 11);
      chk("memread", memread, s == 0 || s == 3);
      chk("memwrite", memwrite, s == 5);
      chk("regwrite", regwrite, s == 4 || s == 7 || s == 10);
      chk("branch", branch, s == 8);
      chk("illegal_op", illegal_op, ill && s == 1);
      chk("mem_timeout", mem_timeout, q[k].widx == LIMIT);
      chk("aluop", aluop, (s == 6) ? 2 : ((s == 8) ? 1 : 0));
      if (memread || memwrite) chk("iord", iord, s != 0);
      if (regwrite) begin
        chk("memtoreg", memtoreg, s == 4);
        chk("regdst", regdst, s == 7);
      end
      if (s == 6 || s == 8) chk("alusrca", alusrca, 1);
      if (s == 8) chk("pcsource_beq", pcsource, 1);
      if (s == 11) chk("pcsource_j", pcsource, 2);
      if (s == 0) chk("alusrcb_fetch", alusrcb, 1);
      if (s == 1) chk("alusrcb_decode", alusrcb, 3);
    end
  endtask

  initial begin
    logic [5:0] rop;
    int         kind;
    reset     = 1'b1;
    mem_ready = 1'b0;
    op        = 6'd0;
    do_reset();

    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 0, 3, -1);
    run_instr(6'b000100, 0, 0, -1);
    run_instr(6'b000010, 1, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(6'b001000, 6, 0, -1);
    run_instr(6'b101011, 0, 6, 5);
    do_reset();
    run_instr(6'b001000, 2, 0, -1);
    run_instr(6'b101011, 0, 0, -1);

    repeat (150) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: rop = 6'b000000;
        1: rop = 6'b100011;
        2: rop = 6'b101011;
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        5: rop = 6'b000010;
        default: begin
          rop = 6'($urandom);
          while (legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0,
                ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : 0,
                -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
